div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
Multi-cycle 32/32 restoring divider for DIV/DIVU in the EX stage. It sits directly upstream of the HI/LO register file and drives its write port.
- Remainder goes to HI, quotient goes to LO.
- The pipeline is stalled while the division is in progress.

Parameters:
WIDTH, 32, operand/result width in bits
ZERO_QUOT, 32'hFFFF_FFFF, quotient produced on divide-by-zero

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  request a division; sampled only in IDLE
signed_div  input  1  1 = DIV (two's complement), 0 = DIVU
cancel  input  1  flush from exception/branch; aborts the operation
dividend  input  WIDTH  rs operand; sampled with start
divisor  input  WIDTH  rt operand; sampled with start
busy  output  1  high whenever state != IDLE
stallreq  output  1  pipeline stall request (combinational)
done  output  1  one-cycle pulse, result valid
hilo_we  output  1  HI/LO write enable; equals done
hi_wdata  output  WIDTH  remainder
lo_wdata  output  WIDTH  quotient

Behaviour:
- **Reset**: state IDLE, all internal registers cleared. Outputs busy=0, done=0, hilo_we=0, hi_wdata=0, lo_wdata=0.
- **States**: IDLE, ZERO, ON, END.
- **IDLE**:
  - start=1 & cancel=0 & divisor==0 -> ZERO.
  - start=1 & cancel=0 & divisor!=0 -> ON. Latch |dividend| and |divisor| (absolute value only if signed_div). Latch sign flags: quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend). Clear the iteration counter.
  - start=1 & cancel=1 -> stay IDLE; cancel wins.
- **ON**:
  - One restoring step per cycle: shift the {rem, quot} pair left 1 bit, trial-subtract the divisor, keep the result if no borrow, set the quotient bit.
  - The counter increments each cycle. After 32 steps -> END.
- **ZERO**: next cycle -> END, with lo = ZERO_QUOT and hi = dividend (raw, unsigned interpretation).
- **END**:
  - Apply the sign fix-up (negate quotient/remainder per the latched flags; 32-bit wrap). Register the results into hi_wdata/lo_wdata.
  - done=1 and hilo_we=1 for exactly this cycle. Next state is IDLE.
- **Latency**: start accepted at cycle 0; done at cycle 33 (ZERO path: cycle 2).
- **Result hold**: hi_wdata/lo_wdata hold their value until the next END. They are not cleared by start.
- **stallreq** = (IDLE & start & ~cancel) | ON | ZERO. It is low in END, so the instruction advances in the same cycle its result is written.
- **Ignored start**: start while busy is ignored; operands are not resampled.
- **Cancel**: cancel=1 in ON, ZERO or END -> IDLE next cycle. done/hilo_we are forced 0 in that cycle. hi_wdata/lo_wdata are unchanged.
- **Signed overflow**: 0x80000000 / 0xFFFFFFFF needs no special case. It yields lo=0x80000000, hi=0 through the wrap arithmetic.
- **rst mid-operation**: returns to IDLE and clears outputs; no done pulse is produced.

Decomposition:
- **Shared CPU package**:
  - div state enum (IDLE/ZERO/ON/END)
  - DIV_ITER=32
  - counter width 6
  - ZERO_QUOT constant
- **One sub-module, div_step**: combinational single restoring step. Inputs: rem, quot, divisor. Outputs: next rem, next quot.
- Control, abs/negate logic and output registers live in div_unit.

Test Plan:
- **Unsigned basic**: DIVU 100/7, start at cycle 0 -> stallreq high cycles 0-32; done=hilo_we=1 at cycle 33; lo=14, hi=2; stallreq=0 at cycle 33.
- **Signed mixed signs**: DIV 0xFFFFFFF9/2 (-7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- **Signed overflow**: DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- **Unsigned edge**: DIVU 0xFFFFFFFF/2 -> lo=0x7FFFFFFF, hi=1.
- **Divide by zero**: DIVU 5/0 -> done at cycle 2, lo=0xFFFFFFFF, hi=5.
- **Cancel and ignored start**:
  - cancel at cycle 10 of a division -> busy=0 at cycle 11; no done/hilo_we ever; outputs keep their previous result.
  - A new start at cycle 11 (DIVU 9/3) -> done at cycle 44, lo=3, hi=0.
  - start with cancel in IDLE -> nothing happens.
  - rst asserted at cycle 5 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU unit: state encoding,
// iteration count and the divide-by-zero quotient.
package div_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ZERO = 2'd1,
    S_ON   = 2'd2,
    S_END  = 2'd3
  } div_state_e;

  localparam int          DIV_ITER      = 32;
  localparam int          CNT_W         = 6;
  localparam logic [31:0] ZERO_QUOT_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_unit_if.sv
// EX-stage request/result bundle between the pipeline and the divider;
// the result half feeds the HI/LO register file write port.
interface div_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             signed_div;
  logic             cancel;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             stallreq;
  logic             done;
  logic             hilo_we;
  logic [WIDTH-1:0] hi_wdata;
  logic [WIDTH-1:0] lo_wdata;

  modport master (
    output start, signed_div, cancel, dividend, divisor,
    input  busy, stallreq, done, hilo_we, hi_wdata, lo_wdata
  );

  modport slave (
    input  start, signed_div, cancel, dividend, divisor,
    output busy, stallreq, done, hilo_we, hi_wdata, lo_wdata
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on magnitudes: shift {rem, quot}
// left, trial-subtract the divisor, keep the difference when nothing borrows.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    trial = {rem_i, quot_i[WIDTH-1]};
    diff  = trial - {1'b0, divisor_i};
    if (!diff[WIDTH]) begin
      rem_o  = diff[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o  = trial[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// 32/32 restoring divider for DIV/DIVU: magnitudes are divided over 32 cycles,
// signs are restored in END, remainder -> HI and quotient -> LO.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] ZERO_QUOT = ZERO_QUOT_DEF
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] step_rem, step_quot;
  logic [WIDTH-1:0] rem_fix, quot_fix;
  logic             dvd_neg, dvs_neg, done_w;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic             en);
    logic signed [WIDTH-1:0] sx;
    sx = x;
    return en ? WIDTH'(-sx) : x;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  assign dvd_neg  = bus.signed_div & bus.dividend[WIDTH-1];
  assign dvs_neg  = bus.signed_div & bus.divisor[WIDTH-1];
  assign rem_fix  = cond_neg(rem_q, rneg_q);
  assign quot_fix = cond_neg(quot_q, qneg_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.cancel) begin
          cnt_d = '0;
          if (bus.divisor == '0) begin
            // Results are staged so the END fix-up passes them through untouched.
            state_d = S_ZERO;
            rem_d   = bus.dividend;
            quot_d  = ZERO_QUOT;
            dvs_d   = bus.divisor;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
          end else begin
            state_d = S_ON;
            rem_d   = '0;
            quot_d  = cond_neg(bus.dividend, dvd_neg);
            dvs_d   = cond_neg(bus.divisor, dvs_neg);
            qneg_d  = dvd_neg ^ dvs_neg;
            rneg_d  = dvd_neg;
          end
        end
      end
      S_ON: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIV_ITER - 1)) state_d = S_END;
        end
      end
      S_ZERO: state_d = bus.cancel ? S_IDLE : S_END;
      S_END: begin
        state_d = S_IDLE;
        if (!bus.cancel) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // The new result is presented during END itself so the write lines up with done.
  assign done_w       = (state_q == S_END) && !bus.cancel;
  assign bus.done     = done_w;
  assign bus.hilo_we  = done_w;
  assign bus.hi_wdata = done_w ? rem_fix  : hi_q;
  assign bus.lo_wdata = done_w ? quot_fix : lo_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.stallreq = ((state_q == S_IDLE) && bus.start && !bus.cancel) ||
                        (state_q == S_ON) || (state_q == S_ZERO);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes reference results, a monitor
// pops and compares them whenever done is presented.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_hi = 32'h0;
  logic [31:0] last_lo = 32'h0;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32), .ZERO_QUOT(32'hFFFF_FFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division; signed case uses 64-bit arithmetic
  // (truncating toward zero, remainder takes the dividend's sign).
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                output logic [31:0] hi, output logic [31:0] lo);
    int     ia, ib;
    longint sa, sb64, q, r;
    if (b == 32'h0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (!s) begin
      lo = a / b;
      hi = a % b;
    end else begin
      ia   = a;
      ib   = b;
      sa   = ia;
      sb64 = ib;
      q    = sa / sb64;
      r    = sa % sb64;
      lo   = q[31:0];
      hi   = r[31:0];
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    chk("hilo_we_eq_done", {31'h0, bus.hilo_we}, {31'h0, bus.done});
    if (bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("lo_quot", bus.lo_wdata, e.lo);
        chk("hi_rem", bus.hi_wdata, e.hi);
        chk("done_cycle", 32'(cyc), 32'(e.due));
        chk("stall_at_done", {31'h0, bus.stallreq}, 32'h0);
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; start is held for exactly this cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s, input bit push);
    exp_t e;
    bus.start      = 1'b1;
    bus.signed_div = s;
    bus.dividend   = a;
    bus.divisor    = b;
    if (push) begin
      model(a, b, s, e.hi, e.lo);
      e.due = cyc + ((b == 32'h0) ? 2 : 33);
      sb.push_back(e);
    end
    @(negedge clk);
    chk("stall_c0", {31'h0, bus.stallreq}, 32'h1);
    next_cycle();
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  // Cycle-exact done/stallreq profile; optional stray start at cycle glitch_k.
  task automatic run_check(input int lat, input int glitch_k);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("done_profile", {31'h0, bus.done}, {31'h0, k == lat});
      chk("stall_profile", {31'h0, bus.stallreq}, {31'h0, k < lat});
      if (k == glitch_k) begin
        bus.start    = 1'b1;
        bus.dividend = 32'h1;
        bus.divisor  = 32'h1;
      end
      if (k == glitch_k + 1) bus.start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk("idle_timeout", {31'h0, seen}, 32'h1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, bus.done}, 32'h0);
    chk({tag, "_hilo_we"}, {31'h0, bus.hilo_we}, 32'h0);
    chk({tag, "_hi"}, bus.hi_wdata, 32'h0);
    chk({tag, "_lo"}, bus.lo_wdata, 32'h0);
    chk({tag, "_stall"}, {31'h0, bus.stallreq}, 32'h0);
  endtask

  initial begin
    logic [31:0] a, b;
    bit          s;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.cancel     = 1'b0;
    bus.dividend   = 32'h0;
    bus.divisor    = 32'h0;
    repeat (3) next_cycle();
    chk_all_zero("reset");
    rst = 1'b0;
    next_cycle();

    issue(32'd100, 32'd7, 1'b0, 1'b1);          run_check(33, 0);
    next_cycle(); issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);        run_check(33, 0);
    next_cycle(); issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);        run_check(33, 0);
    next_cycle(); issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1); run_check(33, 0);
    next_cycle(); issue(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);        run_check(33, 3);
    next_cycle(); issue(32'd5, 32'd0, 1'b0, 1'b1);                run_check(2, 0);

    // Cancel during cycle 10, restart in cycle 11.
    next_cycle();
    issue(32'd12345, 32'd17, 1'b0, 1'b0);
    repeat (9) next_cycle();
    bus.cancel = 1'b1;
    @(negedge clk);
    chk("cancel_no_done", {31'h0, bus.done}, 32'h0);
    next_cycle();
    bus.cancel = 1'b0;
    chk("cancel_busy", {31'h0, bus.busy}, 32'h0);
    chk("cancel_hold_hi", bus.hi_wdata, last_hi);
    chk("cancel_hold_lo", bus.lo_wdata, last_lo);
    issue(32'd9, 32'd3, 1'b0, 1'b1);
    run_check(33, 0);

    // start together with cancel in IDLE does nothing.
    next_cycle();
    bus.start    = 1'b1;
    bus.cancel   = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    @(negedge clk);
    chk("idle_cancel_stall", {31'h0, bus.stallreq}, 32'h0);
    next_cycle();
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    chk("idle_cancel_busy", {31'h0, bus.busy}, 32'h0);
    chk("idle_cancel_hold_lo", bus.lo_wdata, last_lo);

    // Reset in the middle of a division.
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (4) next_cycle();
    rst = 1'b1;
    next_cycle();
    chk_all_zero("mid_rst");
    rst     = 1'b0;
    last_hi = 32'h0;
    last_lo = 32'h0;

    for (int i = 0; i < 40; i++) begin
      next_cycle();
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      s = $urandom_range(0, 1);
      issue(a, b, s, 1'b1);
      wait_idle();
    end

    repeat (3) next_cycle();
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
